// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter
//   Round-robin arbiter/sequencer that shares one sequential shift-add
//   multiplier among NUM_REQ requesters. One job is in flight at a time:
//   the winning requester's operands are latched, the multiplier is started,
//   and the product (or a watchdog error) is returned to that requester.
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_rst           asynchronous active-high reset (shared with the multiplier)
//   i_req           per-requester request level
//   i_req_a/_b      packed operands, slice i is [i*WIDTH +: WIDTH]
//   o_gnt           one-hot grant pulse (same cycle as o_mul_start)
//   o_resp_valid    one-hot response pulse
//   o_resp_product  product for the responding requester (0 on timeout)
//   o_resp_err      high with o_resp_valid when the watchdog fired
//   o_busy          high whenever a job is in progress
//   o_mul_start     start pulse to the multiplier
//   o_mul_a/_b      operands to the multiplier, stable for the whole job
//   i_mul_done      multiplier done strobe (only honoured while waiting)
//   i_mul_product   multiplier result, valid while i_mul_done is high
module multiplier_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_resp_valid,
  output logic [2*WIDTH-1:0]       o_resp_product,
  output logic                     o_resp_err,
  output logic                     o_busy,
  output logic                     o_mul_start,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  input  logic                     i_mul_done,
  input  logic [2*WIDTH-1:0]       i_mul_product
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_last;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic                 r_start;
  logic                 r_busy;

  logic [IW-1:0]        w_sel;
  logic                 w_any;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first set request scanning upward from last+1,
  // wrapping once. The candidate never exceeds 2*NUM_REQ-1, so a single
  // conditional subtraction implements the modulo.
  always_comb begin
    int cand;
    cand  = 0;
    w_any = 1'b0;
    w_sel = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(r_last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!w_any && i_req[cand]) begin
        w_any = 1'b1;
        w_sel = IW'(cand);
      end
    end
  end

  // All outputs are registers set on the transition into the state in which
  // they are visible, so nothing is combinationally decoded from i_req.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last       <= LAST_RST;
      r_a          <= '0;
      r_b          <= '0;
      r_prod       <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_a     <= i_req_a[w_sel*WIDTH +: WIDTH];
            r_b     <= i_req_b[w_sel*WIDTH +: WIDTH];
            r_gnt   <= onehot(w_sel);
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_gnt   <= '0;
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done strobe takes priority over a watchdog expiring in the
          // same cycle.
          if (i_mul_done) begin
            r_prod       <= i_mul_product;
            r_err        <= 1'b0;
            r_resp_valid <= onehot(r_owner);
            r_state      <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_prod       <= '0;
            r_err        <= 1'b1;
            r_resp_valid <= onehot(r_owner);
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_resp_valid <= '0;
          r_last       <= r_owner;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt          = r_gnt;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_product = r_prod;
  assign o_resp_err     = r_err;
  assign o_busy         = r_busy;
  assign o_mul_start    = r_start;
  assign o_mul_a        = r_a;
  assign o_mul_b        = r_b;

endmodule

// File: tb/tb_multiplier_arbiter.sv
module tb_multiplier_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, resp_valid;
  logic [2*W-1:0]   resp_product;
  logic             resp_err, busy, mul_start;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_done;
  logic [2*W-1:0]   mul_product;

  multiplier_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_a(req_a), .i_req_b(req_b),
    .o_gnt(gnt), .o_resp_valid(resp_valid), .o_resp_product(resp_product),
    .o_resp_err(resp_err), .o_busy(busy), .o_mul_start(mul_start),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_done(mul_done),
    .i_mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level reference: one job at a time, timeline in cycles.
  bit m_active = 0;
  int m_gnt_cyc, m_resp_cyc, m_owner, m_last, m_lat, m_a, m_b, m_prod;
  bit m_err;
  int next_lat = 2;

  // Multiplier stub state
  bit stub_job = 0;
  int stub_done_at = -1;
  int stray_at = -1;
  bit rand_stray = 0;

  typedef struct {
    logic [N-1:0]   r;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             lat;
    logic [N-1:0]   eg;
    int             ep;
    bit             ee;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_last   = N - 1;
    stub_job = 0;
    stray_at = -1;
  endtask

  // Called with the request levels present at the end of cycle cyc.
  task automatic model_sample();
    bit found;
    found = 0;
    if (rst) return;
    if (m_active && cyc <= m_resp_cyc) return;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (!found && req[idx]) begin
        found     = 1;
        m_owner   = idx;
        m_a       = int'(req_a[idx*W +: W]);
        m_b       = int'(req_b[idx*W +: W]);
        m_gnt_cyc = cyc + 1;
        m_lat     = next_lat;
        if (m_lat >= 1 && m_lat <= TO) begin
          m_resp_cyc = m_gnt_cyc + m_lat + 1;
          m_prod     = m_a * m_b;
          m_err      = 0;
        end else begin
          m_resp_cyc = m_gnt_cyc + TO + 1;
          m_prod     = 0;
          m_err      = 1;
        end
        m_last   = idx;
        m_active = 1;
      end
    end
  endtask

  task automatic stub_update();
    bit job_fire, stray_fire, in_wait;
    job_fire   = 0;
    stray_fire = 0;
    in_wait    = m_active && cyc > m_gnt_cyc && cyc < m_resp_cyc;
    if (mul_start === 1'b1) begin
      stub_job     = 1;
      stub_done_at = (m_lat == 0) ? -1 : cyc + m_lat;
    end
    if (stub_job && cyc == stub_done_at) begin
      job_fire = 1;
      stub_job = 0;
    end
    if (cyc == stray_at) stray_fire = 1;
    if (rand_stray && !in_wait && ($urandom % 8 == 0)) stray_fire = 1;
    mul_done = job_fire | stray_fire;
    if (job_fire) mul_product = mul_a * mul_b;
    else          mul_product = (2*W)'($urandom);
  endtask

  task automatic check_cycle();
    logic [N-1:0] eg, erv;
    bit eb;
    eg  = '0;
    erv = '0;
    if (m_active && cyc == m_gnt_cyc)  eg[m_owner]  = 1'b1;
    if (m_active && cyc == m_resp_cyc) erv[m_owner] = 1'b1;
    eb = m_active && cyc >= m_gnt_cyc && cyc <= m_resp_cyc;
    check("gnt", 32'(gnt), 32'(eg));
    check("mul_start", 32'(mul_start), 32'(|eg));
    check("resp_valid", 32'(resp_valid), 32'(erv));
    check("busy", 32'(busy), 32'(eb));
    if (erv != '0) begin
      check("resp_product", 32'(resp_product), 32'(m_prod));
      check("resp_err", 32'(resp_err), 32'(m_err));
    end
    if (eb) begin
      check("mul_a", 32'(mul_a), 32'(m_a));
      check("mul_b", 32'(mul_b), 32'(m_b));
    end
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    stub_update();
    check_cycle();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One request pattern from idle to response, with explicit expectations.
  task automatic do_job(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input int lat, input logic [N-1:0] eg,
                        input int ep, input bit ee);
    int waited, t0, edelta;
    req_a    = a;
    req_b    = b;
    req      = r;
    next_lat = lat;
    waited   = 0;
    while (gnt == '0 && waited < 8) begin tick(); waited++; end
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    t0  = cyc;
    req = '0;
    waited = 0;
    while (resp_valid == '0 && waited < 60) begin tick(); waited++; end
    edelta = (lat >= 1 && lat <= TO) ? lat + 1 : TO + 1;
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(eg));
    check({tag, "_product"}, 32'(resp_product), 32'(ep));
    check({tag, "_err"}, 32'(resp_err), 32'(ee));
    check({tag, "_latency"}, 32'(cyc - t0), 32'(edelta));
    tick();
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ng, waited, cnt_g, cnt_r;
    tbl[0] = '{4'b0100, 16'h0D00, 16'h0B00, 3,  4'b0100, 143, 1'b0};
    tbl[1] = '{4'b1111, 16'h907F, 16'h953F, 4,  4'b1000, 81,  1'b0};
    tbl[2] = '{4'b1111, 16'h907F, 16'h953F, 2,  4'b0001, 225, 1'b0};
    tbl[3] = '{4'b1010, 16'h907F, 16'h953F, 5,  4'b0010, 21,  1'b0};
    tbl[4] = '{4'b1010, 16'hC07F, 16'hA53F, 3,  4'b1000, 120, 1'b0};
    tbl[5] = '{4'b1010, 16'hC07F, 16'hA53F, 1,  4'b0010, 21,  1'b0};
    tbl[6] = '{4'b0001, 16'h0009, 16'h0009, 0,  4'b0001, 0,   1'b1};
    tbl[7] = '{4'b0010, 16'h00F0, 16'h00F0, TO, 4'b0010, 225, 1'b0};
    tbl[8] = '{4'b0010, 16'h0060, 16'h0050, TO-1, 4'b0010, 30, 1'b0};
    tbl[9] = '{4'b1000, 16'h0000, 16'hF000, 1,  4'b1000, 0,   1'b0};

    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    mul_done = 1'b0; mul_product = '0;
    model_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_product", 32'(resp_product), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++)
      do_job($sformatf("vec%0d", v), tbl[v].r, tbl[v].a, tbl[v].b, tbl[v].lat,
             tbl[v].eg, tbl[v].ep, tbl[v].ee);

    // All four held high from reset: grants rotate 0,1,2,3,0.
    pulse_reset();
    req_a = 16'hF753; req_b = 16'h8642; next_lat = 2; req = 4'b1111;
    ng = 0; waited = 0;
    while (ng < 5 && waited < 200) begin
      tick(); waited++;
      if (gnt != '0) begin
        check("order_gnt", 32'(gnt), 32'(1 << (ng % 4)));
        ng++;
        if (ng == 5) req = '0;
      end
    end
    check("order_count", 32'(ng), 32'd5);
    waited = 0;
    while (busy && waited < 60) begin tick(); waited++; end
    tick();

    // Requester 0 raises then withdraws while requester 2 is served.
    req_a = 16'h0503; req_b = 16'h0504; next_lat = 8; req = 4'b0100;
    waited = 0;
    while (gnt == '0 && waited < 8) begin tick(); waited++; end
    check("wd_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick(); tick();
    req[0] = 1'b1;
    tick(); tick(); tick();
    req[0] = 1'b0;
    cnt_g = 0; cnt_r = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != '0) cnt_g++;
      if (resp_valid != '0) cnt_r++;
    end
    check("wd_gnt_count", 32'(cnt_g), 32'd0);
    check("wd_resp_count", 32'(cnt_r), 32'd1);

    // Stray done strobe while idle.
    stray_at = cyc + 2;
    cnt_r = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid != '0 || busy) cnt_r++;
    end
    check("stray_activity", 32'(cnt_r), 32'd0);
    do_job("after_stray", 4'b0001, 16'h0003, 16'h0004, 2, 4'b0001, 12, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    req_a = 16'h0900; req_b = 16'h0700; next_lat = 0; req = 4'b0100;
    waited = 0;
    while (gnt == '0 && waited < 8) begin tick(); waited++; end
    req = '0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_mul_start", 32'(mul_start), 32'd0);
    check("arst_mul_a", 32'(mul_a), 32'd0);
    check("arst_mul_b", 32'(mul_b), 32'd0);
    check("arst_resp_product", 32'(resp_product), 32'd0);
    check("arst_resp_err", 32'(resp_err), 32'd0);
    tick(); tick();
    rst = 1'b0;
    cnt_r = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid != '0) cnt_r++;
    end
    check("arst_no_resp", 32'(cnt_r), 32'd0);
    do_job("post_reset", 4'b1111, 16'h555B, 16'h555D, 3, 4'b0001, 143, 1'b0);

    // Randomized traffic against the timeline model.
    rand_stray = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          if ($urandom % 2 == 0) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
          end else begin
            req[i] = 1'b0;
          end
        end else if (req[i]) begin
          if ($urandom % 16 == 0) req[i] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          req[i] = 1'b1;
          req_a[i*W +: W] = W'($urandom);
          req_b[i*W +: W] = W'($urandom);
        end
      end
      case ($urandom % 16)
        0:       next_lat = 0;
        1:       next_lat = TO;
        2:       next_lat = TO - 1;
        default: next_lat = 1 + int'($urandom % 6);
      endcase
      tick();
    end
    rand_stray = 0;
    req = '0;
    waited = 0;
    while (busy && waited < 80) begin tick(); waited++; end
    check("drain_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
